// File: rtl/sbox_lookup_sequencer.sv
// DES S-box lookup sequencer: walks the eight 6-bit chunks of one expanded word,
// drives box/row/col selects into the external S-box ROM and assembles the 32-bit result.
module sbox_lookup_sequencer #(
  parameter int NBOX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [6*NBOX-1:0]    i_in_data,
  output logic [2:0]           o_lut_box,
  output logic [1:0]           o_lut_row,
  output logic [3:0]           o_lut_col,
  input  logic [3:0]           i_lut_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [4*NBOX-1:0]    o_out_data,
  output logic                 o_busy
);

  localparam int IW = 6 * NBOX;
  localparam int OW = 4 * NBOX;
  localparam int KW = (NBOX > 1) ? $clog2(NBOX) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NBOX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [IW-1:0]   r_data;
  logic [OW-1:0]   r_acc;
  logic [1:0]      r_rstSync;

  logic            w_rstn;
  logic            w_run;
  logic [5:0]      w_chunk;
  logic [OW-1:0]   w_accNext;

  // Assertion follows rst_n immediately; release is aligned to clk by two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstSync <= 2'b00;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_rstn = r_rstSync[1];

  // The captured word shifts left one chunk per lookup, so the current chunk is always the top 6 bits.
  assign w_run     = (r_state == RUN);
  assign w_chunk   = r_data[IW-1 -: 6];
  assign w_accNext = (r_acc << 4) | OW'(i_lut_data);

  assign o_lut_box  = w_run ? 3'(r_k) : 3'd0;
  assign o_lut_row  = w_run ? {w_chunk[5], w_chunk[0]} : 2'd0;
  assign o_lut_col  = w_run ? w_chunk[4:1] : 4'd0;
  assign o_in_ready = (r_state == IDLE);
  assign o_busy     = (r_state == RUN) || (r_state == DONE);

  always_ff @(posedge clk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_data      <= '0;
      r_acc       <= '0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_data  <= i_in_data;
            r_k     <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_data <= r_data << 6;
          if (r_k == KLAST) begin
            o_out_data  <= w_accNext;
            o_out_valid <= 1'b1;
            r_acc       <= '0;
            r_k         <= '0;
            r_state     <= DONE;
          end else begin
            r_acc <= w_accNext;
            r_k   <= r_k + 1'b1;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_lookup_sequencer.sv
// Directed bench for sbox_lookup_sequencer: a partial DES S-box ROM or a col-echo stub answers lookups,
// and every expected value below is hand-computed from the DES example word.
module tb_sbox_lookup_sequencer;

  logic        clk;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [47:0] i_in_data;
  logic [2:0]  o_lut_box;
  logic [1:0]  o_lut_row;
  logic [3:0]  o_lut_col;
  logic [3:0]  i_lut_data;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out_data;
  logic        o_busy;

  logic        stubMode;
  int          assertCount;
  int          failCount;

  localparam logic [47:0] DES_WORD = 48'h6117BA866527;
  localparam logic [31:0] DES_COLS = 32'hC8FD03A3;
  localparam logic [15:0] DES_ROWS = {2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd0, 2'd3};
  localparam logic [31:0] DES_OUT  = 32'h5C82B597;

  sbox_lookup_sequencer #(.NBOX(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_lut_box   (o_lut_box),
    .o_lut_row   (o_lut_row),
    .o_lut_col   (o_lut_col),
    .i_lut_data  (i_lut_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only the eight DES S-box entries touched by the example word; everything else returns 0.
  function automatic logic [3:0] desLookup(input logic [2:0] box, input logic [1:0] row, input logic [3:0] col);
    case ({box, row, col})
      9'b000_00_1100: return 4'h5;
      9'b001_01_1000: return 4'hC;
      9'b010_00_1111: return 4'h8;
      9'b011_10_1101: return 4'h2;
      9'b100_11_0000: return 4'hB;
      9'b101_10_0011: return 4'h5;
      9'b110_00_1010: return 4'h9;
      9'b111_11_0011: return 4'h7;
      default:        return 4'h0;
    endcase
  endfunction

  always_comb begin
    i_lut_data = 4'h0;
    if (stubMode) i_lut_data = o_lut_col;
    else          i_lut_data = desLookup(o_lut_box, o_lut_row, o_lut_col);
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one word for exactly one accepting edge; returns 1 time unit after that edge.
  task automatic applyStimulus(input logic [47:0] data);
    i_in_valid = 1'b1;
    i_in_data  = data;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  // Called right after the accepting edge; checks all eight lookups and the finished word.
  task automatic checkRun(input logic [31:0] cols, input logic [15:0] rows, input logic [31:0] result);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("lut_box[%0d]", k), 64'(o_lut_box), 64'(k));
      checkOutput($sformatf("lut_col[%0d]", k), 64'(o_lut_col), 64'(cols[31-4*k -: 4]));
      checkOutput($sformatf("lut_row[%0d]", k), 64'(o_lut_row), 64'(rows[15-2*k -: 2]));
      checkOutput($sformatf("run_valid[%0d]", k), 64'(o_out_valid), 64'd0);
      checkOutput($sformatf("run_busy[%0d]", k), 64'({o_busy, o_in_ready}), 64'b10);
      @(posedge clk); #1;
    end
    checkOutput("done_valid", 64'(o_out_valid), 64'd1);
    checkOutput("done_data", 64'(o_out_data), 64'(result));
    checkOutput("done_in_ready", 64'(o_in_ready), 64'd0);
    checkOutput("done_lut", 64'({o_lut_box, o_lut_row, o_lut_col}), 64'd0);
  endtask

  task automatic finishHandshake(input logic [31:0] result);
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    checkOutput("hs_valid", 64'(o_out_valid), 64'd0);
    checkOutput("hs_in_ready", 64'(o_in_ready), 64'd1);
    checkOutput("hs_data_kept", 64'(o_out_data), 64'(result));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    stubMode    = 1'b0;
    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_out_ready = 1'b0;

    #23;
    checkOutput("rst_in_ready", 64'(o_in_ready), 64'd1);
    checkOutput("rst_valid_busy", 64'({o_out_valid, o_busy}), 64'd0);
    checkOutput("rst_out_data", 64'(o_out_data), 64'd0);
    checkOutput("rst_lut", 64'({o_lut_box, o_lut_row, o_lut_col}), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Real DES lookups on the textbook example word.
    applyStimulus(DES_WORD);
    checkRun(DES_COLS, DES_ROWS, DES_OUT);

    // Backpressure: result held, new input ignored.
    i_in_valid = 1'b1;
    i_in_data  = 48'hFFFFFFFFFFFF;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      checkOutput("bp_hold", 64'({o_out_valid, o_in_ready, o_busy, o_out_data}), {31'd0, 1'b1, 1'b0, 1'b1, DES_OUT});
    end
    i_in_valid = 1'b0;
    finishHandshake(DES_OUT);
    @(posedge clk); #1;
    checkOutput("idle_busy", 64'(o_busy), 64'd0);

    // Stub ROM echoes the column: all-ones and all-zeros words.
    stubMode = 1'b1;
    applyStimulus(48'hFFFFFFFFFFFF);
    checkRun(32'hFFFFFFFF, 16'hFFFF, 32'hFFFFFFFF);
    finishHandshake(32'hFFFFFFFF);
    applyStimulus(48'h000000000000);
    checkRun(32'h00000000, 16'h0000, 32'h00000000);
    finishHandshake(32'h00000000);

    // Back-to-back with in_valid held high: second accept lands 10 edges after the first.
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1;
    i_in_data   = DES_WORD;
    @(posedge clk); #1;
    i_in_data = 48'hFFFFFFFFFFFF;
    checkOutput("b2b_accept_a", 64'(o_busy), 64'd1);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("b2b_e7_valid", 64'(o_out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("b2b_e8_valid", 64'(o_out_valid), 64'd1);
    checkOutput("b2b_result_a", 64'(o_out_data), 64'(DES_COLS));
    @(posedge clk); #1;
    checkOutput("b2b_e9_idle", 64'({o_in_ready, o_out_valid, o_busy}), 64'b100);
    @(posedge clk); #1;
    checkOutput("b2b_e10_accept", 64'({o_in_ready, o_busy}), 64'b01);
    i_in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("b2b_result_b_valid", 64'(o_out_valid), 64'd1);
    checkOutput("b2b_result_b", 64'(o_out_data), 64'hFFFFFFFF);
    @(posedge clk); #1;
    checkOutput("b2b_end_idle", 64'(o_in_ready), 64'd1);
    i_out_ready = 1'b0;

    // Reset in the middle of RUN, then a clean DES word.
    stubMode = 1'b0;
    applyStimulus(DES_WORD);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_at_k4", 64'(o_lut_box), 64'd4);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", 64'(o_in_ready), 64'd1);
    checkOutput("abort_valid_busy", 64'({o_out_valid, o_busy}), 64'd0);
    checkOutput("abort_out_data", 64'(o_out_data), 64'd0);
    checkOutput("abort_lut", 64'({o_lut_box, o_lut_row, o_lut_col}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_reset_idle", 64'({o_in_ready, o_busy}), 64'b10);
    applyStimulus(DES_WORD);
    checkRun(DES_COLS, DES_ROWS, DES_OUT);
    finishHandshake(DES_OUT);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/sbox_lookup_sequencer.md
Name: sbox_lookup_sequencer

Overview:
- Upstream controller for the DES S-box lookup path.
- Accepts one 48-bit S-box input word (expanded R XOR round subkey) per transaction.
- Walks the eight 6-bit chunks one per cycle and drives box/row/column selects into the mux-based S-box ROM (16:1 column muxes, row/box muxing outside this block).
- Samples the returned 4-bit nibble each cycle and assembles the 32-bit substitution result for the P-permutation stage.

Parameters:
- NBOX, default 8: number of S-boxes. Input width is 6*NBOX, output width is 4*NBOX. Only 8 is required for DES; other values must elaborate.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept in_data
- in_data  input  6*NBOX  S-box input word; chunk for box 1 = MSBs [47:42]
- lut_box  output  3  S-box index (0 = box 1) for the current lookup
- lut_row  output  2  row select = {b5,b0} of the current chunk
- lut_col  output  4  column select = b4..b1 of the current chunk (drives 16:1 mux sel)
- lut_data  input  4  combinational ROM return for the current box/row/col
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  4*NBOX  substitution result; box 1 nibble in MSBs [31:28]
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async on rst_n low, released synchronously by the design's reset sync):
  - state=IDLE, k=0.
  - in_ready=1, out_valid=0, busy=0.
  - out_data=0, lut_box/lut_row/lut_col=0, internal input and accumulator registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; lut_* driven 0.
  - On an edge with in_valid=1: capture in_data, k<=0, go to RUN.
- RUN:
  - in_ready=0.
  - Chunk c = captured[6*NBOX-1-6k -: 6]; lut_box=k, lut_row={c[5],c[0]}, lut_col=c[4:1]. All are registered-state derived, so they are stable the whole cycle.
  - Each edge: acc <= {acc[4*NBOX-5:0], lut_data}, k<=k+1.
  - On the edge where k==NBOX-1: capture the last nibble, load out_data with the completed word, out_valid<=1, go to DONE.
  - Counter never wraps inside RUN; k is cleared on entry.
- DONE:
  - out_valid=1, in_ready=0, lut_* driven 0.
  - out_data is held stable until the handshake.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE. out_data retains its value afterwards.
- Latency:
  - Input handshake at edge E0; lookups occur in cycles E0..E7.
  - out_valid rises after E8 (8 cycles for NBOX=8).
  - Minimum period is 10 cycles per word (no overlap of DONE and accept).
- Handshake rules:
  - in_valid while busy is ignored and causes no capture.
  - out_ready while out_valid=0 is ignored.
  - out_valid never drops without out_ready.
- Backpressure: out_ready held low keeps DONE indefinitely, and in_ready stays 0.
- Reset mid-RUN or mid-DONE: immediate abort to reset values. No partial result is ever presented.
- lut_data is don't-care outside RUN and must not affect state.

Test Plan:
- Real DES S-box model on lut_*: in_data=0x6117BA866527 -> lut_col sequence C,8,F,D,0,3,A,3 on boxes 0..7; out_valid after 8 cycles; out_data=0x5C82B597.
- Stub lut_data=lut_col: in_data=0xFFFFFFFFFFFF -> out_data=0xFFFFFFFF. in_data=0x000000000000 -> out_data=0x00000000. lut_row=3 and 0 respectively on every lookup.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid and out_data stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high with two words, out_ready=1 -> second word accepted exactly 10 cycles after the first, both results correct.
- Reset: assert rst_n=0 at k=4 -> all outputs 0 asynchronously. After release, new word 0x6117BA866527 -> 0x5C82B597 with no residue from the aborted word.
